// File: rtl/scratch_pad_port_arbiter_pkg.sv
// Shared helpers for the scratch pad port arbiter: width derivation for IDs and counters.
package scratch_pad_port_arbiter_pkg;

  // Ceiling log2, never below 1 so single-entry structures still get a bit.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned bits;
    bits = 1;
    while ((32'd1 << bits) < value) bits++;
    return bits;
  endfunction

  function automatic int unsigned req_bits(input int unsigned requesters);
    return log2(requesters - 1);
  endfunction

  function automatic int unsigned cnt_bits(input int unsigned max_outstanding);
    return log2(max_outstanding) + 1;
  endfunction

endpackage

// File: rtl/scratch_pad_port_arbiter_tag_fifo.sv
// FIFO of requester IDs for outstanding reads; head is presented combinationally.
module scratch_pad_port_arbiter_tag_fifo
  import scratch_pad_port_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] d,
  input  logic             pop,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrBits = log2(DEPTH);
  localparam int unsigned CntBits = log2(DEPTH) + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PtrBits-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntBits-1:0] count_q;
  logic               push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntBits'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign q       = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= (wr_ptr_q == PtrBits'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrBits'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == PtrBits'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrBits'(1);
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + CntBits'(1);
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - CntBits'(1);
      end
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= d;
    end
  end

endmodule

// File: rtl/scratch_pad_port_arbiter.sv
// Round-robin sharing of one scratch pad port; in-order read responses are routed back by tag.
module scratch_pad_port_arbiter
  import scratch_pad_port_arbiter_pkg::*;
#(
  parameter int unsigned REQUESTERS      = 4,
  parameter int unsigned WIDTH           = 64,
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter int unsigned MAX_OUTSTANDING = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [0:REQUESTERS-1]            req_rd_en,
  input  logic [0:REQUESTERS-1]            req_wr_en,
  input  logic [ADDR_WIDTH*REQUESTERS-1:0] req_addr,
  input  logic [WIDTH*REQUESTERS-1:0]      req_d,
  output logic [0:REQUESTERS-1]            req_grant,
  output logic [0:REQUESTERS-1]            req_valid,
  output logic [WIDTH-1:0]                 req_q,
  input  logic [0:REQUESTERS-1]            req_stall,
  output logic                             sp_rd_en,
  output logic                             sp_wr_en,
  output logic [ADDR_WIDTH-1:0]            sp_addr,
  output logic [WIDTH-1:0]                 sp_d,
  input  logic                             sp_full,
  input  logic                             sp_valid,
  input  logic [WIDTH-1:0]                 sp_q,
  output logic                             sp_stall,
  output logic                             err
);

  localparam int unsigned REQ_BITS = req_bits(REQUESTERS);
  localparam int unsigned CNT_BITS = cnt_bits(MAX_OUTSTANDING);

  logic [REQ_BITS-1:0]   ptr_q;
  logic [CNT_BITS-1:0]   outstanding_q;
  logic                  sp_rd_en_q, sp_wr_en_q, err_q;
  logic [ADDR_WIDTH-1:0] sp_addr_q;
  logic [WIDTH-1:0]      sp_d_q;

  logic [ADDR_WIDTH-1:0] addr_arr [REQUESTERS];
  logic [WIDTH-1:0]      d_arr    [REQUESTERS];
  logic [0:REQUESTERS-1] eligible;
  logic                  rd_ok, gnt_found, gnt_rd, gnt_wr, gnt_both;
  logic [REQ_BITS-1:0]   gnt_idx, idx;

  logic                  fifo_empty, fifo_full, route, pop;
  logic [REQ_BITS-1:0]   head;

  // Requester i sits in the most-significant end of the flattened buses.
  always_comb begin
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      addr_arr[i] = req_addr[(REQUESTERS - 1 - i) * ADDR_WIDTH +: ADDR_WIDTH];
      d_arr[i]    = req_d[(REQUESTERS - 1 - i) * WIDTH +: WIDTH];
    end
  end

  always_comb begin
    rd_ok = (outstanding_q < CNT_BITS'(MAX_OUTSTANDING)) && !fifo_full;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      eligible[i] = req_wr_en[i] | (req_rd_en[i] & rd_ok);
    end
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    idx       = ptr_q;
    if (rst && !sp_full) begin
      for (int unsigned j = 0; j < REQUESTERS; j++) begin
        idx = ptr_q + REQ_BITS'(j);
        if (!gnt_found && eligible[idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = idx;
        end
      end
    end
    req_grant = '0;
    if (gnt_found) begin
      req_grant[gnt_idx] = 1'b1;
    end
    gnt_wr   = gnt_found & req_wr_en[gnt_idx];
    gnt_rd   = gnt_found & req_rd_en[gnt_idx] & ~req_wr_en[gnt_idx];
    gnt_both = gnt_found & req_rd_en[gnt_idx] & req_wr_en[gnt_idx];
  end

  always_comb begin
    route     = rst & sp_valid & ~fifo_empty;
    req_valid = '0;
    if (route) begin
      req_valid[head] = 1'b1;
    end
    sp_stall = route & req_stall[head];
    pop      = route & ~req_stall[head];
    req_q    = sp_q;
  end

  scratch_pad_port_arbiter_tag_fifo #(
    .WIDTH(REQ_BITS),
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (gnt_rd),
    .d    (gnt_idx),
    .pop  (pop),
    .q    (head),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q         <= '0;
      outstanding_q <= '0;
      sp_rd_en_q    <= 1'b0;
      sp_wr_en_q    <= 1'b0;
      sp_addr_q     <= '0;
      sp_d_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      sp_rd_en_q <= gnt_rd;
      sp_wr_en_q <= gnt_wr;
      if (gnt_found) begin
        sp_addr_q <= addr_arr[gnt_idx];
        sp_d_q    <= d_arr[gnt_idx];
        ptr_q     <= gnt_idx + REQ_BITS'(1);
      end
      if (gnt_rd && !pop) begin
        outstanding_q <= outstanding_q + CNT_BITS'(1);
      end else if (pop && !gnt_rd) begin
        outstanding_q <= outstanding_q - CNT_BITS'(1);
      end
      if (gnt_both || (sp_valid && fifo_empty)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign sp_rd_en = sp_rd_en_q;
  assign sp_wr_en = sp_wr_en_q;
  assign sp_addr  = sp_addr_q;
  assign sp_d     = sp_d_q;
  assign err      = err_q;

endmodule

// File: tb/tb_scratch_pad_port_arbiter.sv
// Directed and randomized checks of scratch_pad_port_arbiter against a queue-based model.
module tb_scratch_pad_port_arbiter;

  localparam int unsigned R  = 4;
  localparam int unsigned W  = 64;
  localparam int unsigned AW = 12;
  localparam int unsigned MO = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [0:R-1]  req_rd_en, req_wr_en, req_grant, req_valid, req_stall;
  logic [AW*R-1:0] req_addr;
  logic [W*R-1:0]  req_d;
  logic [W-1:0]  req_q, sp_d, sp_q;
  logic [AW-1:0] sp_addr;
  logic          sp_rd_en, sp_wr_en, sp_full, sp_valid, sp_stall, err;

  always #5 clk = ~clk;

  scratch_pad_port_arbiter #(
    .REQUESTERS(R), .WIDTH(W), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst), .req_rd_en(req_rd_en), .req_wr_en(req_wr_en),
    .req_addr(req_addr), .req_d(req_d), .req_grant(req_grant), .req_valid(req_valid),
    .req_q(req_q), .req_stall(req_stall), .sp_rd_en(sp_rd_en), .sp_wr_en(sp_wr_en),
    .sp_addr(sp_addr), .sp_d(sp_d), .sp_full(sp_full), .sp_valid(sp_valid),
    .sp_q(sp_q), .sp_stall(sp_stall), .err(err)
  );

  // Reference model: outstanding reads as a queue of (requester, expected data).
  typedef struct { int id; logic [W-1:0] data; } tag_t;
  tag_t          mq[$];
  logic [W-1:0]  mmem [logic [AW-1:0]];
  int            ptr;
  bit            m_err, e_rd, e_wr;
  logic [AW-1:0] e_addr;
  logic [W-1:0]  e_d;
  logic [0:R-1]  last_grant;
  // Behavioural scratch pad driven by the DUT's issue port.
  logic [W-1:0]  spmem [logic [AW-1:0]];
  logic [W-1:0]  sp_resp[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    if (sp_full) return -1;
    for (int j = 0; j < R; j++) begin
      int k;
      k = (ptr + j) % R;
      if (req_wr_en[k] || (req_rd_en[k] && mq.size() < MO)) return k;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [W-1:0] d);
    req_rd_en[i] = rd;
    req_wr_en[i] = wr;
    req_addr[(R-1-i)*AW +: AW] = a;
    req_d[(R-1-i)*W +: W] = d;
  endtask

  task automatic drive_resp(input bit want);
    sp_valid = want && (sp_resp.size() > 0);
    sp_q = (sp_resp.size() > 0) ? sp_resp[0] : {$urandom, $urandom};
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step();
    int k, h;
    logic [0:R-1] eg, ev;
    bit es, route;
    logic [W-1:0] rdata;
    #1;
    k = pick();
    eg = '0;
    if (k >= 0) eg[k] = 1'b1;
    route = sp_valid && (mq.size() > 0);
    ev = '0;
    es = 1'b0;
    if (route) begin
      h = mq[0].id;
      ev[h] = 1'b1;
      es = req_stall[h];
    end
    chk("grant", req_grant, eg);
    chk("req_valid", req_valid, ev);
    chk("sp_stall", sp_stall, es);
    if (route) chk("req_q", req_q, mq[0].data);
    chk("sp_rd_en", sp_rd_en, e_rd);
    chk("sp_wr_en", sp_wr_en, e_wr);
    if (e_rd || e_wr) chk("sp_addr", sp_addr, e_addr);
    if (e_wr) chk("sp_d", sp_d, e_d);
    chk("err", err, m_err);
    @(posedge clk);
    if (sp_valid && mq.size() == 0) m_err = 1'b1;
    if (route && !es) void'(mq.pop_front());
    if (sp_valid && !es && sp_resp.size() > 0) void'(sp_resp.pop_front());
    e_rd = 1'b0;
    e_wr = 1'b0;
    last_grant = eg;
    if (k >= 0) begin
      ptr = (k + 1) % R;
      e_addr = req_addr[(R-1-k)*AW +: AW];
      e_d = req_d[(R-1-k)*W +: W];
      if (req_wr_en[k]) begin
        e_wr = 1'b1;
        mmem[e_addr] = e_d;
        if (req_rd_en[k]) m_err = 1'b1;
      end else begin
        e_rd = 1'b1;
        rdata = mmem.exists(e_addr) ? mmem[e_addr] : '0;
        mq.push_back('{k, rdata});
      end
    end
    @(negedge clk);
    if (sp_wr_en) spmem[sp_addr] = sp_d;
    if (sp_rd_en) sp_resp.push_back(spmem.exists(sp_addr) ? spmem[sp_addr] : '0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_grant", req_grant, '0);
    chk("rst_valid", req_valid, '0);
    chk("rst_sp_stall", sp_stall, 1'b0);
    chk("rst_sp_rd_en", sp_rd_en, 1'b0);
    chk("rst_sp_wr_en", sp_wr_en, 1'b0);
    chk("rst_sp_addr", sp_addr, '0);
    chk("rst_sp_d", sp_d, '0);
    chk("rst_err", err, 1'b0);
    req_rd_en = '0; req_wr_en = '0; req_stall = '0;
    sp_valid = 1'b0; sp_full = 1'b0;
    mq.delete(); sp_resp.delete();
    ptr = 0; m_err = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_d = '0;
    last_grant = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:R-1] rot [5];
    int guard;
    rot = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    rst = 1'b0;
    req_rd_en = '0; req_wr_en = '0; req_stall = '0; req_addr = '0; req_d = '0;
    sp_full = 1'b0; sp_valid = 1'b0; sp_q = '0;
    @(negedge clk);
    do_reset();

    // 1: write then read back through requester 1
    set_req(1, 0, 1, 12'h010, 64'hDEAD);
    #1 chk("t1_wr_grant", req_grant, 4'b0100);
    step();
    set_req(1, 1, 0, 12'h010, '0);
    #1 chk("t1_rd_grant", req_grant, 4'b0100);
    step();
    set_req(1, 0, 0, '0, '0);
    #1 chk("t1_rd_issue", sp_rd_en, 1'b1);
    chk("t1_rd_addr", sp_addr, 12'h010);
    step();
    drive_resp(1);
    #1 chk("t1_valid", req_valid, 4'b0100);
    chk("t1_q", req_q, 64'hDEAD);
    step();
    drive_resp(0);

    // 2: rotation with all requesters writing
    do_reset();
    for (int i = 0; i < R; i++) set_req(i, 0, 1, 12'h100 + AW'(i), 64'hA000 + W'(i));
    for (int s = 0; s < 5; s++) begin
      #1 chk("t2_rotate", req_grant, rot[s]);
      step();
    end
    for (int i = 0; i < R; i++) set_req(i, 0, 0, '0, '0);
    step();

    // 3: reads from 2, 0, 3 return in order
    set_req(2, 1, 0, 12'h102, '0); step(); set_req(2, 0, 0, '0, '0);
    set_req(0, 1, 0, 12'h100, '0); step(); set_req(0, 0, 0, '0, '0);
    set_req(3, 1, 0, 12'h103, '0); step(); set_req(3, 0, 0, '0, '0);
    drive_resp(1); #1 chk("t3_v2", req_valid, 4'b0010); chk("t3_qa", req_q, 64'hA002); step();
    drive_resp(1); #1 chk("t3_v0", req_valid, 4'b1000); step();
    drive_resp(1); #1 chk("t3_v3", req_valid, 4'b0001); chk("t3_qc", req_q, 64'hA003); step();
    drive_resp(0); step();

    // 4: requester 0 stalls its response for three cycles
    set_req(0, 1, 0, 12'h101, '0); step(); set_req(0, 0, 0, '0, '0); step();
    req_stall[0] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      drive_resp(1);
      #1 chk("t4_stall", sp_stall, 1'b1);
      step();
    end
    req_stall[0] = 1'b0;
    drive_resp(1);
    #1 chk("t4_release", sp_stall, 1'b0);
    chk("t4_valid", req_valid, 4'b1000);
    step();
    drive_resp(0);

    // 5: outstanding limit, then sp_full
    set_req(0, 1, 0, 12'h020, '0);
    for (int s = 0; s < MO; s++) step();
    set_req(1, 0, 1, 12'h030, 64'h5555);
    #1 chk("t5_wr_past_limit", req_grant, 4'b0100); step();
    #1 chk("t5_wr_past_limit2", req_grant, 4'b0100); step();
    set_req(1, 0, 0, '0, '0);
    #1 chk("t5_rd_blocked", req_grant, 4'b0000); step();
    drive_resp(1);
    #1 chk("t5_rd_blocked_pop", req_grant, 4'b0000); step();
    drive_resp(0);
    #1 chk("t5_slot_freed", req_grant, 4'b1000); step();
    #1 chk("t5_slot_used", req_grant, 4'b0000); step();
    set_req(0, 0, 0, '0, '0);
    guard = 0;
    while (sp_resp.size() > 0 && guard < 200) begin
      drive_resp(1); step(); guard++;
    end
    drive_resp(0);
    for (int i = 0; i < R; i++) set_req(i, 0, 1, 12'h040 + AW'(i), 64'h77 + W'(i));
    sp_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1 chk("t5_full", req_grant, 4'b0000); step();
    end
    sp_full = 1'b0;
    for (int i = 0; i < R; i++) set_req(i, 0, 0, '0, '0);
    step();

    // 6: protocol errors
    do_reset();
    sp_valid = 1'b1; sp_q = 64'h1234;
    #1 chk("t6_empty_valid", req_valid, 4'b0000); step();
    sp_valid = 1'b0;
    #1 chk("t6_empty_err", err, 1'b1); step();
    do_reset();
    set_req(3, 1, 1, 12'h050, 64'hBEEF);
    #1 chk("t6_both_grant", req_grant, 4'b0001); step();
    set_req(3, 0, 0, '0, '0);
    #1 chk("t6_both_err", err, 1'b1);
    chk("t6_both_wr", sp_wr_en, 1'b1);
    chk("t6_both_rd", sp_rd_en, 1'b0);
    step();
    do_reset();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < R; i++) begin
        if (!(req_rd_en[i] | req_wr_en[i]) || last_grant[i]) begin
          case ($urandom_range(0, 3))
            0: set_req(i, 0, 0, '0, '0);
            1, 2: set_req(i, 1, 0, AW'($urandom_range(0, 15)), '0);
            default: set_req(i, 0, 1, AW'($urandom_range(0, 15)), {$urandom, $urandom});
          endcase
        end
        req_stall[i] = ($urandom_range(0, 3) == 0);
      end
      sp_full = ($urandom_range(0, 9) == 0);
      drive_resp($urandom_range(0, 9) < 6);
      step();
    end

    // Reset mid-traffic, then the full credit pool must be available again
    for (int i = 0; i < R; i++) set_req(i, 0, 1, AW'(i), 64'h1);
    do_reset();
    set_req(2, 1, 0, 12'h005, '0);
    for (int s = 0; s < MO + 1; s++) begin
      drive_resp(0);
      step();
    end
    #1 chk("post_rst_limit", req_grant, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
